// File: rtl/sram_pkg.sv
// sram_pkg: shared state encoding and lane-merge helper for the masked-write SRAM.
package sram_pkg;
  typedef enum logic {INIT, READY} state_e;
  localparam int MAX_DW = 1024;
  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_DW-1:0] bit_mask
  );
    return (old_w & ~bit_mask) | (new_w & bit_mask);
  endfunction
endpackage

// File: rtl/sram_init_seq.sv
// sram_init_seq: post-reset sweep that zeroes every word once, then holds READY until reset.
module sram_init_seq
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk0,
  input  logic                  rst0,
  output logic                  init_done,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  last;
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q    <= INIT;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end
  always_comb begin
    last       = clr_addr_q == '1;
    state_d    = (state_q == INIT && last) ? READY : state_q;
    clr_addr_d = (state_q == INIT && !last) ? clr_addr_q + 1'b1 : clr_addr_q;
  end
  always_comb begin
    init_done = state_q == READY;
    clr_we    = state_q == INIT;
    clr_addr  = clr_addr_q;
  end
endmodule

// File: rtl/sram_1rw1r_wmask.sv
// sram_1rw1r_wmask: 1RW + 1R SRAM with lane write mask, registered inputs and outputs.
// Define SRAM_RW_FORWARD_EN to make port 1 see the post-write word on a same-address collision.
module sram_1rw1r_wmask
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int WMASK_WIDTH = 2
) (
  input  logic                   clk0,
  input  logic                   rst0,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  output logic                   dout0_vld,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dout1_vld,
  output logic                   init_done
);
  localparam int LANE = DATA_WIDTH / WMASK_WIDTH;
  logic [DATA_WIDTH-1:0]  mem_q [2**ADDR_WIDTH];
  logic                   csb0_q, csb0_d, web0_q, web0_d, csb1_q, csb1_d;
  logic [WMASK_WIDTH-1:0] wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0]  addr0_q, addr0_d, addr1_q, addr1_d;
  logic [DATA_WIDTH-1:0]  din0_q, din0_d;
  logic [DATA_WIDTH-1:0]  dout0_q, dout0_d, dout1_q, dout1_d;
  logic                   dout0_vld_q, dout0_vld_d, dout1_vld_q, dout1_vld_d;
  logic                   clr_we, rd0, wr0, rd1, mem_we;
  logic [ADDR_WIDTH-1:0]  clr_addr, mem_waddr;
  logic [DATA_WIDTH-1:0]  bit_mask, merged, mem_wdata, rd1_data;
  sram_init_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_init (
    .clk0      (clk0),
    .rst0      (rst0),
    .init_done (init_done),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );
  for (genvar i = 0; i < WMASK_WIDTH; i++) begin : g_mask
    assign bit_mask[i*LANE +: LANE] = {LANE{wmask0_q[i]}};
  end
  // Requests arriving before the sweep finishes are captured as deselected, so they never execute.
  always_comb begin
    csb0_d   = rst0 | ~init_done | csb0;
    csb1_d   = rst0 | ~init_done | csb1;
    web0_d   = rst0 | web0;
    wmask0_d = rst0 ? '0 : wmask0;
    addr0_d  = rst0 ? '0 : addr0;
    addr1_d  = rst0 ? '0 : addr1;
    din0_d   = rst0 ? '0 : din0;
  end
  always_comb begin
    rd0       = ~rst0 & ~csb0_q & web0_q;
    wr0       = ~rst0 & ~csb0_q & ~web0_q;
    rd1       = ~rst0 & ~csb1_q;
    merged    = DATA_WIDTH'(lane_merge(MAX_DW'(mem_q[addr0_q]), MAX_DW'(din0_q), MAX_DW'(bit_mask)));
    mem_we    = clr_we | wr0;
    mem_waddr = clr_we ? clr_addr : addr0_q;
    mem_wdata = clr_we ? '0 : merged;
`ifdef SRAM_RW_FORWARD_EN
    rd1_data  = (wr0 && addr0_q == addr1_q) ? merged : mem_q[addr1_q];
`else
    rd1_data  = mem_q[addr1_q];
`endif
    dout0_d     = rst0 ? '0 : rd0 ? mem_q[addr0_q] : dout0_q;
    dout1_d     = rst0 ? '0 : rd1 ? rd1_data : dout1_q;
    dout0_vld_d = rd0;
    dout1_vld_d = rd1;
  end
  always_ff @(posedge clk0) begin
    csb0_q      <= csb0_d;
    csb1_q      <= csb1_d;
    web0_q      <= web0_d;
    wmask0_q    <= wmask0_d;
    addr0_q     <= addr0_d;
    addr1_q     <= addr1_d;
    din0_q      <= din0_d;
    dout0_q     <= dout0_d;
    dout1_q     <= dout1_d;
    dout0_vld_q <= dout0_vld_d;
    dout1_vld_q <= dout1_vld_d;
  end
  always_ff @(posedge clk0) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end
  assign dout0     = dout0_q;
  assign dout1     = dout1_q;
  assign dout0_vld = dout0_vld_q;
  assign dout1_vld = dout1_vld_q;
endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// tb_sram_1rw1r_wmask: directed checks of init sweep, masked writes, collision and reset abort.
module tb_sram_1rw1r_wmask;
  logic       clk0 = 1'b0, rst0 = 1'b1;
  logic       csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1;
  logic [1:0] wmask0 = '0;
  logic [3:0] addr0 = '0, addr1 = '0;
  logic [7:0] din0 = '0;
  logic [7:0] dout0, dout1;
  logic       dout0_vld, dout1_vld, init_done;
  int         n_chk = 0, n_fail = 0, cycles;
  logic [7:0] coll_exp;

  sram_1rw1r_wmask dut (
    .clk0      (clk0),
    .rst0      (rst0),
    .csb0      (csb0),
    .web0      (web0),
    .wmask0    (wmask0),
    .addr0     (addr0),
    .din0      (din0),
    .dout0     (dout0),
    .dout0_vld (dout0_vld),
    .csb1      (csb1),
    .addr1     (addr1),
    .dout1     (dout1),
    .dout1_vld (dout1_vld),
    .init_done (init_done)
  );

  always #5 clk0 = ~clk0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk0);
    @(negedge clk0);
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = '0;
  endtask

  task automatic wait_init();
    cycles = 0;
    while (!init_done && cycles < 40) begin
      cyc();
      cycles++;
      check("init_vld0", {31'b0, dout0_vld}, 0);
      check("init_vld1", {31'b0, dout1_vld}, 0);
    end
    check("init_cycles", cycles, 16);
  endtask

  task automatic write0(input logic [3:0] a, input logic [7:0] d, input logic [1:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    cyc();
    idle();
    cyc();
    check("wr_vld0", {31'b0, dout0_vld}, 0);
  endtask

  task automatic read_both(input logic [3:0] a0, input logic [3:0] a1,
                           input logic [7:0] e0, input logic [7:0] e1);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a0; csb1 = 1'b0; addr1 = a1;
    cyc();
    idle();
    cyc();
    check("rd_dout0", {24'b0, dout0}, {24'b0, e0});
    check("rd_vld0", {31'b0, dout0_vld}, 1);
    check("rd_dout1", {24'b0, dout1}, {24'b0, e1});
    check("rd_vld1", {31'b0, dout1_vld}, 1);
  endtask

  initial begin
`ifdef SRAM_RW_FORWARD_EN
    coll_exp = 8'hFF;
`else
    coll_exp = 8'h00;
`endif
    repeat (2) cyc();
    check("rst_init_done", {31'b0, init_done}, 0);
    check("rst_dout0", {24'b0, dout0}, 0);
    check("rst_dout1", {24'b0, dout1}, 0);
    check("rst_vld0", {31'b0, dout0_vld}, 0);
    rst0 = 1'b0;
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd2; din0 = 8'hFF; wmask0 = 2'b11;
    csb1 = 1'b0; addr1 = 4'd2;
    wait_init();
    idle();
    for (int i = 0; i < 16; i++) read_both(4'(i), 4'(15 - i), 8'h00, 8'h00);

    write0(4'd3, 8'hA5, 2'b11);
    read_both(4'd3, 4'd3, 8'hA5, 8'hA5);
    cyc();
    check("hold_dout0", {24'b0, dout0}, 32'hA5);
    check("hold_vld0", {31'b0, dout0_vld}, 0);
    write0(4'd3, 8'h3C, 2'b01);
    check("wr_hold_dout0", {24'b0, dout0}, 32'hA5);
    read_both(4'd3, 4'd3, 8'hAC, 8'hAC);
    write0(4'd3, 8'h00, 2'b00);
    read_both(4'd3, 4'd3, 8'hAC, 8'hAC);
    write0(4'd3, 8'h5F, 2'b10);
    read_both(4'd3, 4'd3, 8'h5C, 8'h5C);

    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd5; din0 = 8'hFF; wmask0 = 2'b11;
    csb1 = 1'b0; addr1 = 4'd5;
    cyc();
    idle();
    cyc();
    check("coll_dout1", {24'b0, dout1}, {24'b0, coll_exp});
    check("coll_vld1", {31'b0, dout1_vld}, 1);
    check("coll_vld0", {31'b0, dout0_vld}, 0);
    read_both(4'd5, 4'd3, 8'hFF, 8'h5C);

    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd3; csb1 = 1'b0; addr1 = 4'd5;
    cyc();
    rst0 = 1'b1;
    idle();
    cyc();
    check("abort_dout0", {24'b0, dout0}, 0);
    check("abort_vld0", {31'b0, dout0_vld}, 0);
    check("abort_dout1", {24'b0, dout1}, 0);
    check("abort_vld1", {31'b0, dout1_vld}, 0);
    check("abort_init_done", {31'b0, init_done}, 0);
    rst0 = 1'b0;
    repeat (7) cyc();
    check("mid_init_done", {31'b0, init_done}, 0);
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd3; din0 = 8'h77; wmask0 = 2'b11;
    rst0 = 1'b1;
    cyc();
    rst0 = 1'b0;
    idle();
    wait_init();
    read_both(4'd3, 4'd5, 8'h00, 8'h00);
    read_both(4'd0, 4'd15, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
